// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: frame-aligned pixel FIFO between a pixel producer and a VGA timing generator
// Ports:
//   clk           pixel clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   wr_valid      producer has a pixel
//   wr_ready      FIFO can accept a pixel (registered state only)
//   wr_data       RGB444 pixel, [11:8] R, [7:4] G, [3:0] B
//   wr_sof        wr_data is pixel (0,0) of a frame
//   frame_start   one-cycle pulse before the first visible pixel of a frame
//   rd_en         request for the next visible pixel
//   rd_data       registered pixel to the colour output
//   level         current occupancy, 0..DEPTH
//   underflow_cnt saturating count of reads from an empty FIFO while running
//   synced        high while the output is aligned to the frame (RUN)
module vga_pixel_fifo #(
    parameter int          DEPTH      = 16,
    parameter logic [11:0] FILL_COLOR = 12'h000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [11:0]              wr_data,
    input  logic                     wr_sof,
    input  logic                     frame_start,
    input  logic                     rd_en,
    output logic [11:0]              rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underflow_cnt,
    output logic                     synced
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {RESYNC, RUN} state_t;
    state_t state, state_nx;
    logic [12:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic empty, head_sof, wr, pop;
    assign empty    = level == '0;
    assign head_sof = mem[rd_ptr][12];
    assign wr_ready = level != (AW+1)'(DEPTH);
    assign wr       = wr_valid && wr_ready;
    assign synced   = state == RUN;
    // In RESYNC, entries ahead of the next start-of-frame are dropped until
    // the sof pixel sits at the head; it is then held for frame_start.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        if (state == RESYNC) begin
            pop = !empty && !head_sof;
            if (frame_start && !empty && head_sof) state_nx = RUN;
        end else begin
            pop = rd_en && !empty;
            if (frame_start && (empty || !head_sof)) state_nx = RESYNC;
        end
    end
    always_ff @(posedge clk) begin
        if (wr && !reset) mem[wr_ptr] <= {wr_sof, wr_data};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RESYNC;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            rd_data       <= 12'h000;
            underflow_cnt <= 16'h0000;
        end else begin
            state <= state_nx;
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop) level <= level + (AW+1)'(1);
            else if (pop && !wr) level <= level - (AW+1)'(1);
            if (rd_en) rd_data <= (state == RUN && !empty) ? mem[rd_ptr][11:0] : FILL_COLOR;
            if (rd_en && state == RUN && empty && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb_vga_pixel_fifo: self-checking bench for vga_pixel_fifo
module tb_vga_pixel_fifo;
    localparam int          DEPTH = 8;
    localparam logic [11:0] FILL  = 12'hA5C;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_data = '0;
    logic        wr_sof = 1'b0;
    logic        frame_start = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] rd_data;
    logic [3:0]  level;
    logic [15:0] underflow_cnt;
    logic        synced;
    int errors = 0;
    int checks = 0;
    logic [11:0] sb [$];
    typedef struct packed {
        logic        wv;
        logic [11:0] wd;
        logic        ws;
        logic        fs;
        logic        re;
        logic [11:0] rd;
        logic [3:0]  lvl;
        logic        syn;
    } vec_t;
    vec_t tbl [9];
    vga_pixel_fifo #(.DEPTH(DEPTH), .FILL_COLOR(FILL)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_sof(wr_sof), .frame_start(frame_start),
        .rd_en(rd_en), .rd_data(rd_data), .level(level),
        .underflow_cnt(underflow_cnt), .synced(synced)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic wv, input logic [11:0] wd, input logic ws, input logic fs, input logic re);
        wr_valid = wv;
        wr_data = wd;
        wr_sof = ws;
        frame_start = fs;
        rd_en = re;
    endtask
    task automatic cyc(input logic wv, input logic [11:0] wd, input logic ws, input logic fs, input logic re, input logic [11:0] exp_rd);
        drive(wv, wd, ws, fs, re);
        if (re) sb.push_back(exp_rd);
        tick();
        if (re) chk("rd_data", {20'h0, rd_data}, {20'h0, sb.pop_front()});
        drive(0, 12'h000, 0, 0, 0);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 12'h000, 0, 0, 0);
        chk("reset level", {28'h0, level}, 32'd0);
        chk("reset synced", {31'h0, synced}, 32'd0);
        chk("reset rd_data", {20'h0, rd_data}, 32'h000);
        chk("reset underflow", {16'h0, underflow_cnt}, 32'd0);
        chk("reset wr_ready", {31'h0, wr_ready}, 32'd1);
    endtask
    initial begin
        tbl[0] = '{1'b1, 12'h0F0, 1'b1, 1'b0, 1'b0, 12'h000, 4'd1, 1'b0};
        tbl[1] = '{1'b1, 12'hF00, 1'b0, 1'b0, 1'b0, 12'h000, 4'd2, 1'b0};
        tbl[2] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 12'h000, 4'd3, 1'b0};
        tbl[3] = '{1'b1, 12'h00F, 1'b0, 1'b0, 1'b0, 12'h000, 4'd4, 1'b0};
        tbl[4] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 4'd4, 1'b1};
        tbl[5] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h0F0, 4'd3, 1'b1};
        tbl[6] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'hF00, 4'd2, 1'b1};
        tbl[7] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'hFFF, 4'd1, 1'b1};
        tbl[8] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h00F, 4'd0, 1'b1};
        tick();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].wv, tbl[i].wd, tbl[i].ws, tbl[i].fs, tbl[i].re, tbl[i].rd);
            chk($sformatf("vec%0d level", i), {28'h0, level}, {28'h0, tbl[i].lvl});
            chk($sformatf("vec%0d synced", i), {31'h0, synced}, {31'h0, tbl[i].syn});
        end
        do_reset();
        cyc(1, 12'h111, 0, 0, 0, 0);
        cyc(1, 12'h222, 0, 0, 0, 0);
        chk("resync discard1", {28'h0, level}, 32'd1);
        cyc(1, 12'h333, 0, 0, 0, 0);
        cyc(1, 12'h444, 1, 0, 0, 0);
        chk("resync discard3", {28'h0, level}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("resync hold sof", {28'h0, level}, 32'd1);
        cyc(0, 0, 0, 0, 1, FILL);
        chk("resync no underflow", {16'h0, underflow_cnt}, 32'd0);
        chk("resync read no pop", {28'h0, level}, 32'd1);
        chk("resync synced", {31'h0, synced}, 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("sync after fs", {31'h0, synced}, 32'd1);
        cyc(0, 0, 0, 0, 1, 12'h444);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, FILL);
        chk("underflow 3", {16'h0, underflow_cnt}, 32'd3);
        cyc(1, 12'h555, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("misalign desync", {31'h0, synced}, 32'd0);
        chk("misalign level", {28'h0, level}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("misalign discard", {28'h0, level}, 32'd0);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 12'(16 + i), i == 0, 0, 0, 0);
        chk("full level", {28'h0, level}, DEPTH);
        chk("full ready", {31'h0, wr_ready}, 32'd0);
        cyc(1, 12'h099, 0, 0, 0, 0);
        chk("full refuse", {28'h0, level}, DEPTH);
        cyc(1, 12'h099, 0, 1, 0, 0);
        chk("full sync", {31'h0, synced}, 32'd1);
        drive(1, 12'h099, 0, 0, 1);
        #1;
        chk("pop-cycle ready", {31'h0, wr_ready}, 32'd0);
        sb.push_back(12'h010);
        tick();
        chk("rd_data", {20'h0, rd_data}, {20'h0, sb.pop_front()});
        chk("pop-cycle level", {28'h0, level}, DEPTH - 1);
        cyc(1, 12'h099, 0, 0, 0, 0);
        chk("write after pop", {28'h0, level}, DEPTH);
        for (int i = 1; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 12'(16 + i));
        cyc(0, 0, 0, 0, 1, 12'h099);
        chk("drained", {28'h0, level}, 32'd0);
        for (int i = 0; i < 7; i++) cyc(1, 12'(12'h700 + i), 0, 0, 0, 0);
        chk("pre-reset level", {28'h0, level}, 32'd7);
        drive(1, 12'h777, 1, 1, 1);
        do_reset();
        do_reset();
        cyc(1, 12'h123, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 12'h123);
        rd_en = 1'b1;
        repeat (65537) tick();
        rd_en = 1'b0;
        chk("underflow saturate", {16'h0, underflow_cnt}, 32'h0000FFFF);
        chk("underflow fill", {20'h0, rd_data}, {20'h0, FILL});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 16; FIFO entries; power of two, minimum 4.
REQ-002 The block SHALL have parameter FILL_COLOR, default 12'h000; RGB444 value driven on underflow or while resyncing.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: pixel clock, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: producer has a pixel.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: FIFO can accept a pixel.
REQ-007 The block SHALL have port wr_data, input, 12 bits: pixel, RGB444, bits [11:8] R, [7:4] G, [3:0] B.
REQ-008 The block SHALL have port wr_sof, input, 1 bit: marks wr_data as pixel (0,0) of a frame.
REQ-009 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse from the timing generator, once per frame, before the first visible pixel.
REQ-010 The block SHALL have port rd_en, input, 1 bit: timing generator requests the next visible pixel.
REQ-011 The block SHALL have port rd_data, output, 12 bits: registered pixel to the colour output.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-013 The block SHALL have port underflow_cnt, output, 16 bits: saturating count of underflow reads.
REQ-014 The block SHALL have port synced, output, 1 bit: high while the state is RUN.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries, each 13 bits {sof, data}, with write/read pointers wrapping at DEPTH.
REQ-016 wr_ready SHALL equal (level != DEPTH), derived from registered state only; a same-cycle pop SHALL NOT raise wr_ready.
REQ-017 A write SHALL occur when wr_valid && wr_ready; the entry SHALL be visible to reads from the next cycle (no empty bypass).
REQ-018 level SHALL increment on write-only, decrement on pop-only, and hold when write and pop coincide.
REQ-019 The state machine SHALL have exactly two states, RESYNC and RUN; the state SHALL be RESYNC after reset.
REQ-020 In RESYNC, while not empty and the head entry has sof=0, the block SHALL pop and discard one entry per cycle regardless of rd_en.
REQ-021 In RESYNC, a head entry with sof=1 SHALL be held, not popped.
REQ-022 In RESYNC, rd_en SHALL load rd_data with FILL_COLOR without popping, and SHALL NOT increment underflow_cnt.
REQ-023 In RESYNC, frame_start with non-empty FIFO and head sof=1 SHALL move the state to RUN on the next cycle; otherwise the state SHALL stay RESYNC.
REQ-024 In RUN, rd_en with non-empty FIFO SHALL pop the head and load its data into rd_data, giving exactly one cycle of latency from rd_en to rd_data.
REQ-025 In RUN, rd_en with empty FIFO SHALL load FILL_COLOR and increment underflow_cnt, saturating at 16'hFFFF.
REQ-026 In RUN, frame_start with empty FIFO or head sof=0 SHALL move the state to RESYNC; head sof=1 SHALL keep RUN.
REQ-027 Every state change SHALL take effect on the next cycle; a read or discard in the same cycle as frame_start SHALL be governed by the current state.
REQ-028 When rd_en is low in RUN, rd_data SHALL hold its previous value.
REQ-029 In RUN, a popped entry with sof=1 that is not at frame_start SHALL be output normally, with no state change.

Reset
REQ-030 While reset is high, pointers SHALL clear, level=0, rd_data=12'h000, underflow_cnt=0, state=RESYNC, synced=0, and wr_ready=1 on the cycle after reset.
REQ-031 Reset SHALL override all inputs, including any in-flight write, read, or frame_start.
REQ-032 FIFO contents need not be cleared.

Verification
REQ-033 Scenario: reset, write 4 pixels (first with sof=1, data 12'h0F0,12'hF00,12'hFFF,12'h00F), pulse frame_start, then rd_en for 4 cycles -> synced=1 one cycle after frame_start; rd_data = 0F0,F00,FFF,00F, each one cycle after its rd_en; level returns to 0.
REQ-034 Scenario: write DEPTH pixels with no reads, then hold wr_valid high -> wr_ready=0 at level=DEPTH; with a simultaneous pop, wr_ready stays 0 that cycle and the write is accepted the cycle after.
REQ-035 Scenario: in RUN, drain the FIFO and assert rd_en for 3 more cycles -> rd_data=FILL_COLOR and underflow_cnt=3; preload underflow_cnt near 16'hFFFF via long underflow -> it saturates at 16'hFFFF.
REQ-036 Scenario: in RESYNC, write 3 pixels with sof=0 followed by 1 with sof=1 -> 3 entries are discarded in 3 cycles, the sof entry is held, level=1, and rd_en outputs FILL_COLOR with no underflow count.
REQ-037 Scenario: in RUN, frame_start while head sof=0 -> synced=0 next cycle, and misaligned entries are discarded.
REQ-038 Scenario: reset asserted mid-stream with level=7 -> level=0, synced=0, and rd_data=000 on the next cycle.
